vga_fb_arbiter: RTL

- Sequences the 640x480@60 VGA scan-out (800x525 total raster) and shares one single-port framebuffer RAM between display fetch and a pixel writer (drawing engine or CPU).
- Framebuffer is 160x120 at 3-bit RGB; each framebuffer pixel is scaled 4x4 on screen.
- Display fetch always has priority. Writer requests are granted only in cycles the display does not use.

---
 rtl/vga_fb_arbiter_if.sv | 21 ++
 rtl/vga_fb_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Writer-side handshake into the VGA framebuffer arbiter.
// The writer holds wr_req until it sees the one-clk wr_ack.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 15
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [2:0]        wr_data;
   logic              wr_ack;
   logic              wr_err;

   modport master (
      output wr_req, wr_addr, wr_data,
      input  wr_ack, wr_err
   );

   modport slave (
      input  wr_req, wr_addr, wr_data,
      output wr_ack, wr_err
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// VGA raster sequencer sharing one single-port framebuffer with a writer.
// Define VBLANK_ONLY_WR_EN to restrict writer grants to vertical blanking.
module vga_fb_arbiter #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int FB_W   = H_VIS / 4,
   parameter int FB_H   = V_VIS / 4,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [2:0]        rgb,
   output logic              frame_start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [2:0]        mem_wdata,
   input  logic [2:0]        mem_rdata,
   vga_fb_arbiter_if.slave   wr
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_VISC = HW'(H_VIS);
   localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_VISC = VW'(V_VIS);
   localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC);

   localparam logic [ADDR_W:0]   FB_SIZE = (ADDR_W + 1)'(FB_W * FB_H);
   localparam logic [ADDR_W-1:0] FB_WC   = ADDR_W'(FB_W);

   logic [HW-1:0]     h_cnt;
   logic [HW-1:0]     h_nxt;
   logic [VW-1:0]     v_cnt;
   logic [VW-1:0]     v_nxt;
   logic              vis_cur;
   logic              vis_nxt;
   logic              fetch;
   logic              fetch_q;
   logic              wr_win;
   logic              grant;
   logic              in_range;
   logic [ADDR_W-1:0] faddr;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        pixel_reg;

   always_comb begin
      h_nxt = h_cnt + 1'b1;
      v_nxt = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
   end

   assign vis_cur = (h_cnt < H_VISC) && (v_cnt < V_VISC);
   assign vis_nxt = (h_nxt < H_VISC) && (v_nxt < V_VISC);

   // Look one position ahead so the word lands in pixel_reg in time.
   assign fetch = reset && pix_en && vis_nxt &&
                  (h_nxt[1:0] == 2'b00);

   assign faddr = ADDR_W'(v_nxt >> 2) * FB_WC +
                  ADDR_W'(h_nxt >> 2);

`ifdef VBLANK_ONLY_WR_EN
   assign wr_win = (v_cnt >= V_VISC);
`else
   assign wr_win = 1'b1;
`endif

   assign in_range = {1'b0, wr.wr_addr} < FB_SIZE;
   assign grant    = reset && wr.wr_req && !fetch && wr_win;

   always_comb begin
      mem_addr  = addr_q;
      mem_we    = 1'b0;
      mem_wdata = wr.wr_data;
      wr.wr_ack = 1'b0;
      wr.wr_err = 1'b0;
      unique case (1'b1)
         fetch: begin
            mem_addr = faddr;
         end
         grant: begin
            mem_addr  = wr.wr_addr;
            mem_we    = in_range;
            wr.wr_ack = 1'b1;
            wr.wr_err = !in_range;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         rgb         <= 3'b000;
         frame_start <= 1'b0;
         pixel_reg   <= 3'b000;
         fetch_q     <= 1'b0;
         addr_q      <= '0;
      end else begin
         frame_start <= 1'b0;
         fetch_q     <= fetch;
         addr_q      <= mem_addr;
         if (fetch_q) begin
            pixel_reg <= mem_rdata;
         end
         if (pix_en) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            hsync <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
            vsync <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
            de    <= vis_cur;
            rgb   <= vis_cur ? pixel_reg : 3'b000;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
         end
      end
   end

endmodule
